e203_tb_irq_stim: RTL and testbench

//  Parametrised interrupt-stimulus and end-of-test monitor for e203 simulation benches.

---
 rtl/e203_tb_irq_stim_pkg.sv | 41 ++++
 rtl/e203_tb_irq_stim_chan.sv | 134 +++++++++++++
 rtl/e203_tb_irq_stim.sv | 123 ++++++++++++
 tb/tb_e203_tb_irq_stim.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_tb_irq_stim_pkg.sv
// -----------------------------------------------------------------------------
// e203_tb_irq_stim_pkg
// Shared definitions for the e203 bench interrupt stimulus block:
//   - chan_state_e : per-channel FSM states (IDLE/WAIT/ASSERT/HALT)
//   - LFSR tap mask, per-channel seed spreading constant, zero-seed substitute
//   - lfsr_step()  : one step of the 16-bit Galois LFSR
//   - chan_seed()  : derives channel i's seed from the common seed
//   - sat_inc32()  : saturating 32-bit increment
// -----------------------------------------------------------------------------
package e203_tb_irq_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ASSERT = 2'd2,
    ST_HALT   = 2'd3
  } chan_state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] SEED_MULT     = 16'h9E37;
  localparam logic [15:0] SEED_ZERO_SUB = 16'h0001;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed is replaced.
  function automatic logic [15:0] chan_seed(input logic [15:0] seed, input int unsigned idx);
    logic [15:0] mult;
    logic [15:0] s;
    mult = SEED_MULT * 16'(idx + 1);
    s    = seed ^ mult;
    return (s == 16'h0000) ? SEED_ZERO_SUB : s;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/e203_tb_irq_stim_chan.sv
// -----------------------------------------------------------------------------
// e203_tb_irq_stim_chan
// One interrupt stimulus channel: waits a random gap, raises irq, and holds it
// until the handler PC commits or the assert timeout expires.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              advance enable for FSM, LFSR and timers
//   armed           stimulus armed (sticky, from top)
//   stop            stop request (from top); halts the channel when in WAIT
//   hdl_hit         handler PC committed this cycle
//   seed_init       LFSR value loaded on reset
//   dly_mask        mask applied to the LFSR to form the gap length
//   irq             interrupt drive (high while in ASSERT)
//   irq_cnt         handled-interrupt count, saturating
//   tmo_err         sticky timeout flag
// -----------------------------------------------------------------------------
module e203_tb_irq_stim_chan
  import e203_tb_irq_stim_pkg::*;
#(
  parameter int DLY_W = 10,
  parameter int TMO_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             armed,
  input  logic             stop,
  input  logic             hdl_hit,
  input  logic [15:0]      seed_init,
  input  logic [DLY_W-1:0] dly_mask,
  output logic             irq,
  output logic [15:0]      irq_cnt,
  output logic             tmo_err
);

  localparam logic [TMO_W-1:0] TMO_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [DLY_W:0]   GAP_ONE  = (DLY_W+1)'(1);

  chan_state_e      state_reg, state_next;
  logic [15:0]      lfsr_reg;
  logic [DLY_W:0]   gap_reg, gap_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic [15:0]      irq_cnt_reg, irq_cnt_next;
  logic             tmo_err_reg, tmo_err_next;
  logic [DLY_W:0]   gap_load;

  // One extra bit so the largest gap (mask all ones) of 2**DLY_W fits.
  assign gap_load = {1'b0, lfsr_reg[DLY_W-1:0] & dly_mask} + GAP_ONE;

  always_comb begin
    state_next   = state_reg;
    gap_next     = gap_reg;
    tmo_next     = tmo_reg;
    irq_cnt_next = irq_cnt_reg;
    tmo_err_next = tmo_err_reg;
    if (en) begin
      case (state_reg)
        ST_IDLE: begin
          if (armed) begin
            state_next = ST_WAIT;
            gap_next   = gap_load;
          end
        end
        ST_WAIT: begin
          if (stop) begin
            state_next = ST_HALT;
          end else if (gap_reg == GAP_ONE) begin
            // tmo starts at 1 so that it equals the number of asserted
            // cycles; the timeout fires on the (2**TMO_W-1)-th one.
            state_next = ST_ASSERT;
            tmo_next   = TMO_ONE;
          end else begin
            gap_next = gap_reg - GAP_ONE;
          end
        end
        ST_ASSERT: begin
          if (hdl_hit || (tmo_reg == TMO_MAX)) begin
            // A handler hit takes precedence over a coincident timeout.
            if (hdl_hit) begin
              if (irq_cnt_reg != 16'hFFFF) begin
                irq_cnt_next = irq_cnt_reg + 16'd1;
              end
            end else begin
              tmo_err_next = 1'b1;
            end
            tmo_next = '0;
            if (stop) begin
              state_next = ST_HALT;
            end else begin
              state_next = ST_WAIT;
              gap_next   = gap_load;
            end
          end else begin
            tmo_next = tmo_reg + TMO_ONE;
          end
        end
        ST_HALT: begin
          state_next = ST_HALT;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      lfsr_reg    <= seed_init;
      gap_reg     <= '0;
      tmo_reg     <= '0;
      irq_cnt_reg <= '0;
      tmo_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gap_reg     <= gap_next;
      tmo_reg     <= tmo_next;
      irq_cnt_reg <= irq_cnt_next;
      tmo_err_reg <= tmo_err_next;
      if (en) begin
        lfsr_reg <= lfsr_step(lfsr_reg);
      end
    end
  end

  // Derived from the state register, so irq is glitch-free and rises the
  // cycle after the WAIT->ASSERT transition.
  assign irq     = (state_reg == ST_ASSERT);
  assign irq_cnt = irq_cnt_reg;
  assign tmo_err = tmo_err_reg;

endmodule

// File: rtl/e203_tb_irq_stim.sv
// -----------------------------------------------------------------------------
// e203_tb_irq_stim
// Interrupt stimulus and end-of-test monitor for e203 simulation benches.
// Watches the commit stream, arms stimulus on arm_pc, drives NUM_IRQ irq lines
// with random gaps, counts cycles and tohost commits, and flags completion.
// Ports:
//   clk, rst       bench clock, synchronous active-high reset
//   en             global enable for channel FSMs/LFSRs/timers
//   cmt_valid/pc   commit stream
//   arm_pc         PC that arms the stimulus (sticky)
//   tohost_pc      PC of the write-tohost instruction
//   hdl_pc         per-channel handler PC, channel i at [i*PC_W +: PC_W]
//   dly_mask       gap mask, seed  LFSR seed
//   irq_o          interrupt drive
//   irq_cnt        per-channel handled count, channel i at [i*16 +: 16]
//   tmo_err        per-channel sticky timeout flag
//   cycle_cnt      cycles since reset (saturating)
//   tohost_cnt     tohost commits (saturating)
//   end_cycle      cycle_cnt at the first tohost commit
//   done           END_CNT reached with all irq low (sticky)
// -----------------------------------------------------------------------------
module e203_tb_irq_stim
  import e203_tb_irq_stim_pkg::*;
#(
  parameter int NUM_IRQ  = 3,
  parameter int PC_W     = 32,
  parameter int DLY_W    = 10,
  parameter int TMO_W    = 12,
  parameter int STOP_CNT = 32,
  parameter int END_CNT  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cmt_valid,
  input  logic [PC_W-1:0]         cmt_pc,
  input  logic [PC_W-1:0]         arm_pc,
  input  logic [PC_W-1:0]         tohost_pc,
  input  logic [NUM_IRQ*PC_W-1:0] hdl_pc,
  input  logic [DLY_W-1:0]        dly_mask,
  input  logic [15:0]             seed,
  output logic [NUM_IRQ-1:0]      irq_o,
  output logic [NUM_IRQ*16-1:0]   irq_cnt,
  output logic [NUM_IRQ-1:0]      tmo_err,
  output logic [31:0]             cycle_cnt,
  output logic [31:0]             tohost_cnt,
  output logic [31:0]             end_cycle,
  output logic                    done
);

  logic        armed_reg, armed_next;
  logic        done_reg, done_next;
  logic [31:0] cycle_cnt_reg, cycle_cnt_next;
  logic [31:0] tohost_cnt_reg, tohost_cnt_next;
  logic [31:0] end_cycle_reg, end_cycle_next;
  logic        arm_hit, tohost_hit, stop;

  assign arm_hit    = cmt_valid && (cmt_pc == arm_pc);
  assign tohost_hit = cmt_valid && (cmt_pc == tohost_pc);
  assign stop       = (tohost_cnt_reg > 32'(STOP_CNT));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_chan
      logic hdl_hit;
      assign hdl_hit = cmt_valid && (cmt_pc == hdl_pc[gi*PC_W +: PC_W]);

      e203_tb_irq_stim_chan #(
        .DLY_W (DLY_W),
        .TMO_W (TMO_W)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .armed     (armed_reg),
        .stop      (stop),
        .hdl_hit   (hdl_hit),
        .seed_init (chan_seed(seed, gi)),
        .dly_mask  (dly_mask),
        .irq       (irq_o[gi]),
        .irq_cnt   (irq_cnt[gi*16 +: 16]),
        .tmo_err   (tmo_err[gi])
      );
    end
  endgenerate

  always_comb begin
    armed_next      = armed_reg | arm_hit;
    cycle_cnt_next  = sat_inc32(cycle_cnt_reg);
    tohost_cnt_next = tohost_cnt_reg;
    end_cycle_next  = end_cycle_reg;
    if (tohost_hit) begin
      tohost_cnt_next = sat_inc32(tohost_cnt_reg);
      // Counter is still zero only on the very first hit.
      if (tohost_cnt_reg == 32'd0) begin
        end_cycle_next = cycle_cnt_reg;
      end
    end
    done_next = done_reg | ((tohost_cnt_reg >= 32'(END_CNT)) & ~(|irq_o));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_reg      <= 1'b0;
      done_reg       <= 1'b0;
      cycle_cnt_reg  <= '0;
      tohost_cnt_reg <= '0;
      end_cycle_reg  <= '0;
    end else begin
      armed_reg      <= armed_next;
      done_reg       <= done_next;
      cycle_cnt_reg  <= cycle_cnt_next;
      tohost_cnt_reg <= tohost_cnt_next;
      end_cycle_reg  <= end_cycle_next;
    end
  end

  assign cycle_cnt  = cycle_cnt_reg;
  assign tohost_cnt = tohost_cnt_reg;
  assign end_cycle  = end_cycle_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_e203_tb_irq_stim.sv
// -----------------------------------------------------------------------------
// tb_e203_tb_irq_stim
// Directed bench for e203_tb_irq_stim (3 channels, 4-bit assert timeout).
// Expected values are queued when a step is driven and popped at the check.
// -----------------------------------------------------------------------------
module tb_e203_tb_irq_stim;

  localparam int NUM_IRQ  = 3;
  localparam int PC_W     = 32;
  localparam int DLY_W    = 10;
  localparam int TMO_W    = 4;
  localparam int STOP_CNT = 32;
  localparam int END_CNT  = 8;
  localparam int TRACE_LEN = 1500;

  localparam logic [31:0] ARM_PC    = 32'h8000_0080;
  localparam logic [31:0] TOHOST_PC = 32'h8000_0900;
  localparam logic [31:0] HDL0_PC   = 32'h8000_0100;
  localparam logic [31:0] HDL1_PC   = 32'h8000_0200;
  localparam logic [31:0] HDL2_PC   = 32'h8000_0300;
  localparam logic [15:0] SEED      = 16'h1234;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    en = 1'b1;
  logic                    cmt_valid = 1'b0;
  logic [PC_W-1:0]         cmt_pc = '0;
  logic [PC_W-1:0]         arm_pc = ARM_PC;
  logic [PC_W-1:0]         tohost_pc = TOHOST_PC;
  logic [NUM_IRQ*PC_W-1:0] hdl_pc = {HDL2_PC, HDL1_PC, HDL0_PC};
  logic [DLY_W-1:0]        dly_mask = '0;
  logic [15:0]             seed = SEED;
  logic [NUM_IRQ-1:0]      irq_o;
  logic [NUM_IRQ*16-1:0]   irq_cnt;
  logic [NUM_IRQ-1:0]      tmo_err;
  logic [31:0]             cycle_cnt, tohost_cnt, end_cycle;
  logic                    done;

  always #5 clk = ~clk;

  e203_tb_irq_stim #(
    .NUM_IRQ (NUM_IRQ), .PC_W (PC_W), .DLY_W (DLY_W), .TMO_W (TMO_W),
    .STOP_CNT (STOP_CNT), .END_CNT (END_CNT)
  ) dut (
    .clk (clk), .rst (rst), .en (en), .cmt_valid (cmt_valid), .cmt_pc (cmt_pc),
    .arm_pc (arm_pc), .tohost_pc (tohost_pc), .hdl_pc (hdl_pc),
    .dly_mask (dly_mask), .seed (seed), .irq_o (irq_o), .irq_cnt (irq_cnt),
    .tmo_err (tmo_err), .cycle_cnt (cycle_cnt), .tohost_cnt (tohost_cnt),
    .end_cycle (end_cycle), .done (done)
  );

  // Reference LFSR for channel 0, written from the polynomial description.
  logic [15:0] m_lfsr = 16'h0001;
  logic [15:0] seed0;
  assign seed0 = ((SEED ^ 16'h9E37) == 16'h0) ? 16'h0001 : (SEED ^ 16'h9E37);

  function automatic logic [15:0] m_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;  // feedback into bits 15,13,12,10
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) m_lfsr <= seed0;
    else if (en) m_lfsr <= m_step(m_lfsr);
  end

  function automatic int m_gap();
    logic [DLY_W-1:0] g;
    g = m_lfsr[DLY_W-1:0] & dly_mask;
    return int'(g) + 1;
  endfunction

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   rise_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic [2:0] trace [TRACE_LEN];

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_q.push_back('{tag, v});
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%0h required=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%0h required=%0h (cycle %0d)", e.tag, obs, e.val, cyc);
      end
    end
  endtask

  function automatic logic [15:0] cnt_of(input int i);
    return irq_cnt[i*16 +: 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmt_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic commit(input logic [31:0] pc);
    cmt_valid = 1'b1;
    cmt_pc = pc;
    tick();
    cmt_valid = 1'b0;
    cmt_pc = '0;
  endtask

  initial begin
    int prev0, tmo_end, rises, mism, hits, quiet_bad, sel;
    int hcount [NUM_IRQ];

    // ---------------- Run A: reset state, no arm for 5000 cycles ----------
    en = 1'b1;
    dly_mask = '0;
    do_reset();
    expect_val("reset_irq_o", 32'h0);
    expect_val("reset_cycle_cnt", 32'd0);
    expect_val("reset_tohost_cnt", 32'd0);
    expect_val("reset_done", 32'd0);
    expect_val("reset_tmo_err", 32'd0);
    chk(32'(irq_o));
    chk(cycle_cnt);
    chk(tohost_cnt);
    chk(32'(done));
    chk(32'(tmo_err));
    expect_val("unarmed_irq_o", 32'h0);
    expect_val("unarmed_cycle_cnt", 32'd5000);
    wait_until(5000);
    chk(32'(irq_o));
    chk(cycle_cnt);

    // ---------------- Run B: minimum gap, handler, timeouts, en freeze ----
    do_reset();
    dly_mask = '0;
    wait_until(10);
    expect_val("wait_entry_irq_low", 32'h0);
    expect_val("first_rise_all", 32'h7);
    commit(ARM_PC);                        // armed from cycle 11, WAIT from 12
    wait_until(12); chk(32'(irq_o));
    wait_until(13); chk(32'(irq_o));

    wait_until(16);
    expect_val("ch0_drop_after_hit", 32'h0);
    expect_val("ch0_irq_cnt", 32'd1);
    expect_val("ch0_reassert", 32'h1);
    commit(HDL0_PC);
    chk(32'(irq_o[0]));
    chk(32'(cnt_of(0)));
    wait_until(18); chk(32'(irq_o[0]));

    // ch1/ch2 rose at 13: cycle 27 is their 15th asserted cycle.
    wait_until(27);
    expect_val("tmo_drop_irq_o", 32'h1);
    expect_val("tmo_err_ch1", 32'h2);
    expect_val("hit_at_tmo_cnt2", 32'd1);
    expect_val("no_hit_cnt1", 32'd0);
    expect_val("reassert_after_gap", 32'h7);
    commit(HDL2_PC);
    chk(32'(irq_o));
    chk(32'(tmo_err));
    chk(32'(cnt_of(2)));
    chk(32'(cnt_of(1)));
    wait_until(29); chk(32'(irq_o));

    // Freeze for 20 cycles: irq holds and timers pause.
    en = 1'b0;
    expect_val("freeze_hold", 32'h7);
    wait_until(40); chk(32'(irq_o));
    wait_until(49);
    en = 1'b1;
    expect_val("frozen_ch0_still_high", 32'h7);
    expect_val("ch0_tmo_after_resume", 32'h6);
    expect_val("tmo_err_ch0_ch1", 32'h3);
    wait_until(52); chk(32'(irq_o));
    wait_until(53); chk(32'(irq_o)); chk(32'(tmo_err));
    expect_val("pre_tmo_ch12", 32'h7);
    expect_val("tmo_drop_ch12", 32'h1);
    expect_val("tmo_err_all", 32'h7);
    wait_until(63); chk(32'(irq_o));
    wait_until(64); chk(32'(irq_o)); chk(32'(tmo_err));
    expect_val("all_high_before_rst", 32'h7);
    wait_until(65); chk(32'(irq_o));

    // Reset pulse mid-operation with en toggled low.
    en = 1'b0;
    rst = 1'b1;
    expect_val("rst_irq_o", 32'h0);
    expect_val("rst_irq_cnt_nz", 32'h0);
    expect_val("rst_tmo_err", 32'h0);
    expect_val("rst_cycle_cnt", 32'h0);
    expect_val("rst_end_cycle", 32'h0);
    tick();
    chk(32'(irq_o));
    chk(32'(irq_cnt != '0));
    chk(32'(tmo_err));
    chk(cycle_cnt);
    chk(end_cycle);
    rst = 1'b0;
    en = 1'b1;
    cyc = 0;

    // ---------------- Run C: random gaps, record trace, model ch0 rises ---
    dly_mask = 10'h3FF;
    wait_until(10);
    commit(ARM_PC);
    rise_q.push_back(cyc + 1 + m_gap());   // WAIT entry at end of cycle 11
    prev0 = 0;
    tmo_end = -1;
    rises = 0;
    for (int k = 0; k < TRACE_LEN; k++) begin
      trace[k] = irq_o;
      if (rise_q.size() > 0 && cyc > rise_q[0]) begin
        checks++;
        errors++;
        $error("FAIL ch0_rise_missing: observed=none required=cycle %0d", rise_q[0]);
        void'(rise_q.pop_front());
      end
      if (irq_o[0] && prev0 == 0) begin
        rises++;
        if (rise_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL ch0_rise_unexpected: observed=cycle %0d required=none", cyc);
        end else begin
          expect_val("ch0_rise_cycle", 32'(rise_q.pop_front()));
          chk(32'(cyc));
        end
        tmo_end = cyc + 14;                // no handler: 15 asserted cycles
      end
      if (cyc == tmo_end) rise_q.push_back(cyc + 1 + m_gap());
      prev0 = int'(irq_o[0]);
      tick();
    end
    rise_q.delete();
    expect_val("ch0_rise_seen", 32'h1);
    chk(32'(rises > 0));

    // ---------------- Run D: same seed reproduces the trace ---------------
    do_reset();
    dly_mask = 10'h3FF;
    wait_until(10);
    commit(ARM_PC);
    mism = 0;
    for (int k = 0; k < TRACE_LEN; k++) begin
      if (irq_o !== trace[k]) mism++;
      tick();
    end
    expect_val("trace_replay_mismatches", 32'd0);
    chk(32'(mism));

    // ---------------- Run E: tohost counting, stop and done ---------------
    do_reset();
    dly_mask = 10'h3FF;
    for (int i = 0; i < NUM_IRQ; i++) hcount[i] = 0;
    wait_until(10);
    commit(ARM_PC);
    hits = 0;
    while (!(hits == 34 && irq_o == '0) && cyc < 8000) begin
      cmt_valid = 1'b0;
      if (hits == 0 && cyc == 200) begin
        cmt_valid = 1'b1; cmt_pc = TOHOST_PC; hits++;
      end else if (irq_o != '0) begin
        sel = irq_o[0] ? 0 : (irq_o[1] ? 1 : 2);
        cmt_valid = 1'b1;
        cmt_pc = hdl_pc[sel*PC_W +: PC_W];
        hcount[sel]++;
      end else if (hits > 0 && hits < 34) begin
        cmt_valid = 1'b1; cmt_pc = TOHOST_PC; hits++;
      end
      tick();
    end
    cmt_valid = 1'b0;
    expect_val("tohost_phase_in_budget", 32'h1);
    chk(32'(cyc < 8000));
    expect_val("tohost_cnt", 32'd34);
    chk(tohost_cnt);
    expect_val("end_cycle", 32'd200);
    chk(end_cycle);
    quiet_bad = 0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (irq_o != '0) quiet_bad++;
    end
    expect_val("halted_quiet", 32'd0);
    chk(32'(quiet_bad));
    expect_val("done", 32'h1);
    chk(32'(done));
    expect_val("cycle_cnt_tracks", 32'(cyc));
    chk(cycle_cnt);
    for (int i = 0; i < NUM_IRQ; i++) begin
      expect_val($sformatf("irq_cnt_ch%0d", i), 32'(hcount[i]));
      chk(32'(cnt_of(i)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
